// File: rtl/bitrev_reorder_buf.sv
// ---------------------------------------------------------------------------
// bitrev_reorder_buf
//   Reorders a bit-reversed sample stream (e.g. FFT butterfly output) into
//   natural order. Each incoming frame of N = 2**LOG2N samples is written at
//   bit-reversed addresses into one half of a ping-pong buffer. Completed
//   frames are read out in natural order over a valid/ready interface while
//   the other half fills.
//
// Ports
//   clk        single clock, all state on posedge
//   nrst       synchronous active-low reset
//   in_start   with in_valid: this sample is frame element 0
//   in_valid   in_data valid (no input backpressure)
//   in_data    k-th sample of a frame, belongs at index bitrev(k)
//   out_ready  downstream accepts out_data this cycle
//   out_valid  out_data / out_idx valid
//   out_data   sample in natural order
//   out_idx    natural index of out_data
//   out_last   out_valid && out_idx == N-1
//   ovf        sticky: a frame was dropped because both banks were full
// ---------------------------------------------------------------------------
module bitrev_reorder_buf #(
    parameter int LOG2N = 7,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_start,
    input  logic             in_valid,
    input  logic [DW-1:0]    in_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    output logic [LOG2N-1:0] out_idx,
    output logic             out_last,
    output logic             ovf
);

    localparam int N = 1 << LOG2N;

    localparam logic [LOG2N-1:0] IDX_ZERO = {LOG2N{1'b0}};
    localparam logic [LOG2N-1:0] IDX_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
    localparam logic [LOG2N-1:0] IDX_MAX  = {LOG2N{1'b1}};

    // Write FSM states
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    // Read FSM states: R_ARM is the one-cycle decision point after a bank
    // becomes full or after a frame finishes draining.
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ARM  = 2'd1;
    localparam logic [1:0] R_OUT  = 2'd2;

    // Mirror the bits of an index: bit i moves to bit LOG2N-1-i.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

    // Two banks back to back; the bank number is the address MSB.
    logic [DW-1:0] mem [0:2*N-1];

    logic [0:0]       wstate_q, wstate_d;
    logic [LOG2N-1:0] wcnt_q,   wcnt_d;
    logic             wbank_q,  wbank_d;
    logic [1:0]       rstate_q, rstate_d;
    logic [LOG2N-1:0] rcnt_q,   rcnt_d;
    logic             rbank_q,  rbank_d;
    logic [1:0]       full_q,   full_d;
    logic             ovf_q,    ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [DW-1:0]    out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;

    logic             mem_we;
    logic [LOG2N:0]   mem_waddr;
    logic             set_full;
    logic             clr_full;
    logic             rd_load;
    logic [LOG2N:0]   rd_addr;
    logic [LOG2N-1:0] rcnt_inc;

    assign rcnt_inc = rcnt_q + IDX_ONE;

    // Write side: place samples at bit-reversed addresses, detect frame end.
    always_comb begin
        wstate_d  = wstate_q;
        wcnt_d    = wcnt_q;
        wbank_d   = wbank_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_waddr = {wbank_q, IDX_ZERO};
        set_full  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (in_valid && in_start) begin
                    if (full_q[wbank_q]) begin
                        // No free bank: drop the whole frame.
                        ovf_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = {wbank_q, IDX_ZERO};
                        wcnt_d    = IDX_ONE;
                        wstate_d  = W_FILL;
                    end
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_FILL: begin
                if (in_valid) begin
                    mem_we = 1'b1;
                    if (in_start) begin
                        // Restart in the same bank; the partial frame is lost.
                        mem_waddr = {wbank_q, IDX_ZERO};
                        wcnt_d    = IDX_ONE;
                    end else begin
                        mem_waddr = {wbank_q, bitrev(wcnt_q)};
                        if (wcnt_q == IDX_MAX) begin
                            set_full = 1'b1;
                            wbank_d  = ~wbank_q;
                            wcnt_d   = IDX_ZERO;
                            wstate_d = W_IDLE;
                        end else begin
                            wcnt_d = wcnt_q + IDX_ONE;
                        end
                    end
                end else begin
                    wstate_d = W_FILL;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // Read side: natural-order drain with a held output while stalled.
    always_comb begin
        rstate_d    = rstate_q;
        rcnt_d      = rcnt_q;
        rbank_d     = rbank_q;
        out_valid_d = out_valid_q;
        clr_full    = 1'b0;
        rd_load     = 1'b0;
        rd_addr     = {rbank_q, IDX_ZERO};
        case (rstate_q)
            R_IDLE: begin
                if (full_q[rbank_q]) begin
                    rstate_d = R_ARM;
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_ARM: begin
                if (full_q[rbank_q]) begin
                    rd_load     = 1'b1;
                    rd_addr     = {rbank_q, IDX_ZERO};
                    rcnt_d      = IDX_ZERO;
                    out_valid_d = 1'b1;
                    rstate_d    = R_OUT;
                end else begin
                    rstate_d = R_IDLE;
                end
            end
            R_OUT: begin
                if (out_ready) begin
                    if (rcnt_q == IDX_MAX) begin
                        // Frame done: release the bank and take a one-cycle gap.
                        clr_full    = 1'b1;
                        rbank_d     = ~rbank_q;
                        rcnt_d      = IDX_ZERO;
                        out_valid_d = 1'b0;
                        rstate_d    = R_ARM;
                    end else begin
                        rd_load = 1'b1;
                        rd_addr = {rbank_q, rcnt_inc};
                        rcnt_d  = rcnt_inc;
                    end
                end else begin
                    rstate_d = R_OUT;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                rstate_d    = R_IDLE;
            end
        endcase
    end

    // Output data and status next-state, including bank-full bookkeeping.
    always_comb begin
        full_d = full_q;
        if (set_full) begin
            full_d[wbank_q] = 1'b1;
        end else begin
            full_d[wbank_q] = full_q[wbank_q];
        end
        // Writer and reader always own different banks, so both may apply.
        if (clr_full) begin
            full_d[rbank_q] = 1'b0;
        end else begin
            full_d[rbank_q] = full_d[rbank_q];
        end
        if (rd_load) begin
            out_data_d = mem[rd_addr];
        end else begin
            out_data_d = out_data_q;
        end
        out_last_d = out_valid_d && (rcnt_d == IDX_MAX);
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wstate_q    <= W_IDLE;
            wcnt_q      <= IDX_ZERO;
            wbank_q     <= 1'b0;
            rstate_q    <= R_IDLE;
            rcnt_q      <= IDX_ZERO;
            rbank_q     <= 1'b0;
            full_q      <= 2'b00;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DW{1'b0}};
            out_last_q  <= 1'b0;
        end else begin
            wstate_q    <= wstate_d;
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            rstate_q    <= rstate_d;
            rcnt_q      <= rcnt_d;
            rbank_q     <= rbank_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Sample storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (nrst && mem_we) begin
            mem[mem_waddr] <= in_data;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = rcnt_q;
    assign out_last  = out_last_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// ---------------------------------------------------------------------------
// tb_bitrev_reorder_buf
//   Scoreboard bench. The stimulus tasks build each frame in natural order
//   (sample k lands at bitrev(k)) and push the expected outputs; a negedge
//   monitor pops and compares on every handshake, and also checks stall
//   stability and the one-cycle gap between frames.
// ---------------------------------------------------------------------------
module tb_bitrev_reorder_buf;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_start;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [6:0]  out_idx;
    logic        out_last;
    logic        ovf;

    typedef struct {
        logic [15:0] d;
        logic [6:0]  i;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   frames_done = 0;
    int   frames_drained = 0;
    int   pops = 0;
    int   ready_mode = 1;
    logic exp_ovf = 1'b0;

    bitrev_reorder_buf #(.LOG2N(7), .DW(16)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .in_start  (in_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] bitrev7(input int k);
        logic [6:0] v;
        logic [6:0] r;
        v = k[6:0];
        for (int b = 0; b < 7; b++) r[b] = v[6-b];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // mode 0: data = base + k, mode 1: random data. abort_at > 0 stops early.
    task automatic send_frame(input int mode, input logic [15:0] base,
                              input int gap_pct, input int abort_at);
        logic [15:0] nat [128];
        logic [15:0] d;
        bit          drop;
        int          len;
        exp_t        e;
        len  = (abort_at > 0) ? abort_at : 128;
        drop = 1'b0;
        for (int k = 0; k < len; k++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                in_valid = 1'b0;
                in_start = 1'b0;
                cyc();
            end
            d = (mode == 0) ? base + 16'(k) : 16'($urandom);
            if (k == 0) begin
                drop = (frames_done - frames_drained) >= 2;
                if (drop) exp_ovf = 1'b1;
            end
            nat[bitrev7(k)] = d;
            in_valid = 1'b1;
            in_start = (k == 0);
            in_data  = d;
            if (k == 127 && !drop) begin
                frames_done++;
                for (int i = 0; i < 128; i++) begin
                    e.d = nat[i];
                    e.i = 7'(i);
                    exp_q.push_back(e);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic wait_room();
        int b = 0;
        while ((frames_done - frames_drained) >= 2 && b < 3000) begin
            cyc();
            b++;
        end
        check("room_timeout", b, (b < 3000) ? b : 0);
    endtask

    task automatic drain_wait();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            cyc();
            b++;
        end
        check("drain_timeout", exp_q.size(), 0);
        repeat (4) cyc();
    endtask

    // out_ready pattern generator
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                2:       out_ready = ~out_ready;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: handshakes, stall stability, inter-frame gap
    initial begin
        logic        stall_prev;
        logic [15:0] stall_d;
        logic [6:0]  stall_i;
        int          bubble_state;
        bit          next_ready;
        exp_t        e;
        stall_prev   = 1'b0;
        stall_d      = 16'h0000;
        stall_i      = 7'h00;
        bubble_state = 0;
        next_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                stall_prev   = 1'b0;
                bubble_state = 0;
            end else begin
                if (bubble_state == 1) begin
                    check("gap_low", out_valid, 1'b0);
                    bubble_state = next_ready ? 2 : 0;
                end else if (bubble_state == 2) begin
                    check("resume_after_gap", out_valid, 1'b1);
                    bubble_state = 0;
                end
                if (stall_prev) begin
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_data", out_data, stall_d);
                    check("stall_idx", out_idx, stall_i);
                end
                if (out_valid && out_ready) begin
                    check("queue_nonempty", exp_q.size() != 0, 1'b1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.d);
                        check("out_idx", out_idx, e.i);
                        check("out_last", out_last, e.i == 7'd127);
                        pops++;
                        if (e.i == 7'd127) begin
                            frames_drained++;
                            next_ready   = (frames_done - frames_drained) >= 1;
                            bubble_state = 1;
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                stall_d    = out_data;
                stall_i    = out_idx;
            end
        end
    end

    initial begin
        int b;
        int p0;
        nrst     = 1'b0;
        in_start = 1'b0;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (3) cyc();
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_idx", out_idx, 7'd0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_out_last", out_last, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        cyc();
        nrst = 1'b1;
        cyc();

        // 1: data = k, outputs must be bitrev7(i)
        ready_mode = 1;
        send_frame(0, 16'h0000, 0, 0);
        drain_wait();
        check("t1_ovf", ovf, exp_ovf);

        // 2: back-to-back frames
        send_frame(0, 16'h0000, 0, 0);
        send_frame(0, 16'h0100, 0, 0);
        drain_wait();
        check("t2_ovf", ovf, exp_ovf);

        // 3: three frames while stalled, third dropped
        ready_mode = 0;
        send_frame(0, 16'h0200, 0, 0);
        send_frame(0, 16'h0300, 0, 0);
        send_frame(0, 16'h0400, 0, 0);
        cyc();
        check("t3_ovf_set", ovf, exp_ovf);
        ready_mode = 1;
        drain_wait();

        // 4: ready toggling every cycle
        ready_mode = 2;
        send_frame(1, 16'h0000, 0, 0);
        drain_wait();

        // 5: restart mid-frame at k=50
        ready_mode = 1;
        send_frame(1, 16'h0000, 0, 50);
        send_frame(1, 16'h0000, 0, 0);
        drain_wait();

        // random data, input gaps and random ready
        ready_mode = 3;
        for (int f = 0; f < 5; f++) begin
            wait_room();
            send_frame(1, 16'h0000, 30, 0);
        end
        drain_wait();
        check("rand_ovf", ovf, exp_ovf);

        // 6: reset mid-drain
        ready_mode = 1;
        p0 = pops;
        send_frame(1, 16'h0000, 0, 0);
        b = 0;
        while (pops < p0 + 60 && b < 2000) begin
            cyc();
            b++;
        end
        check("t6_reach_idx60", pops >= p0 + 60, 1'b1);
        nrst = 1'b0;
        cyc();
        nrst = 1'b1;
        exp_q.delete();
        frames_done    = 0;
        frames_drained = 0;
        exp_ovf        = 1'b0;
        @(negedge clk);
        check("t6_out_valid", out_valid, 1'b0);
        check("t6_ovf", ovf, exp_ovf);
        cyc();
        send_frame(1, 16'h0000, 0, 0);
        drain_wait();
        check("t6_pops", pops, p0 + 60 + 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
